// File: rtl/wb_stat_gain.sv
// Gray-world white-balance statistics: per-frame R/G/B sums -> means -> gains (mean_g / mean_c).
// Optional pixel-count check enabled by defining WB_PIXCNT_CHECK_EN.
`timescale 1ns/1ps
module wb_stat_gain #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned LOG2_PIX  = 20,
  parameter int unsigned GAIN_FRAC = 8,
  parameter int unsigned GAIN_W    = 12,
  parameter int unsigned COLOR_W   = 2,
  parameter logic [COLOR_W-1:0] RED   = 2'd0,
  parameter logic [COLOR_W-1:0] GREEN = 2'd1,
  parameter logic [COLOR_W-1:0] BLUE  = 2'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pixel_in,
  input  logic               valid_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               last_pic_in,
  output logic               ready_out,
  output logic [PIX_W-1:0]   mean_r,
  output logic [PIX_W-1:0]   mean_g,
  output logic [PIX_W-1:0]   mean_b,
  output logic [GAIN_W-1:0]  gain_r,
  output logic [GAIN_W-1:0]  gain_g,
  output logic [GAIN_W-1:0]  gain_b,
  output logic               stat_valid,
  output logic               frame_err
);

  localparam int unsigned SUM_W = PIX_W + LOG2_PIX;
  localparam int unsigned Q     = PIX_W + GAIN_FRAC;
  localparam int unsigned CNT_W = $clog2(Q);
  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1) << GAIN_FRAC;

  typedef enum logic [2:0] {S_ACC, S_MEAN, S_DIV_R, S_DIV_B, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [SUM_W-1:0]   sum_r, sum_g, sum_b;
  logic [Q-1:0]       div_num, div_quo;
  logic [PIX_W-1:0]   div_rem;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAIN_W-1:0]  res_r;

  logic               last_bit_c;
  logic [PIX_W-1:0]   mean_g_c;
  logic [PIX_W-1:0]   divisor_c;
  logic [PIX_W:0]     rem_sh_c;
  logic               ge_c;
  logic [PIX_W-1:0]   rem_nxt_c;
  logic [Q-1:0]       quo_nxt_c;

  // Zero divisor or quotient beyond the gain range both clamp to full scale.
  function automatic logic [GAIN_W-1:0] sat_gain(input logic [Q-1:0] quo,
                                                 input logic [PIX_W-1:0] dvs);
    logic [GAIN_W-1:0] g;
    if (dvs == '0)                   g = GAIN_MAX;
    else if (quo > Q'(GAIN_MAX))     g = GAIN_MAX;
    else                             g = GAIN_W'(quo);
    return g;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ACC;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (valid_in && last_pic_in) state_nxt = S_MEAN;
      S_MEAN:  state_nxt = S_DIV_R;
      S_DIV_R: if (last_bit_c) state_nxt = S_DIV_B;
      S_DIV_B: if (last_bit_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // One restoring-division step per cycle on the shared divider
  always_comb begin
    last_bit_c = (bit_cnt == CNT_W'(Q - 1));
    mean_g_c   = PIX_W'(sum_g >> LOG2_PIX);
    divisor_c  = (state == S_DIV_B) ? mean_b : mean_r;
    rem_sh_c   = {div_rem, div_num[Q-1]};
    ge_c       = (rem_sh_c >= {1'b0, divisor_c});
    rem_nxt_c  = ge_c ? PIX_W'(rem_sh_c - {1'b0, divisor_c}) : rem_sh_c[PIX_W-1:0];
    quo_nxt_c  = {div_quo[Q-2:0], ge_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r      <= '0;
      sum_g      <= '0;
      sum_b      <= '0;
      mean_r     <= '0;
      mean_g     <= '0;
      mean_b     <= '0;
      gain_r     <= GAIN_ONE;
      gain_g     <= GAIN_ONE;
      gain_b     <= GAIN_ONE;
      res_r      <= GAIN_ONE;
      div_num    <= '0;
      div_quo    <= '0;
      div_rem    <= '0;
      bit_cnt    <= '0;
      stat_valid <= 1'b0;
      ready_out  <= 1'b1;
    end else begin
      stat_valid <= 1'b0;
      ready_out  <= (state_nxt == S_ACC);
      case (state)
        S_ACC: begin
          if (valid_in) begin
            if (color_in == RED)        sum_r <= sum_r + SUM_W'(pixel_in);
            else if (color_in == GREEN) sum_g <= sum_g + SUM_W'(pixel_in);
            else if (color_in == BLUE)  sum_b <= sum_b + SUM_W'(pixel_in);
          end
        end
        S_MEAN: begin
          mean_r  <= PIX_W'(sum_r >> LOG2_PIX);
          mean_g  <= mean_g_c;
          mean_b  <= PIX_W'(sum_b >> LOG2_PIX);
          div_num <= Q'(mean_g_c) << GAIN_FRAC;
          div_quo <= '0;
          div_rem <= '0;
          bit_cnt <= '0;
        end
        S_DIV_R, S_DIV_B: begin
          div_num <= div_num << 1;
          div_quo <= quo_nxt_c;
          div_rem <= rem_nxt_c;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit_c) begin
            bit_cnt <= '0;
            if (state == S_DIV_R) begin
              // Park the red result and reload the divider for blue.
              res_r   <= sat_gain(quo_nxt_c, mean_r);
              div_num <= Q'(mean_g) << GAIN_FRAC;
              div_quo <= '0;
              div_rem <= '0;
            end else begin
              gain_r     <= res_r;
              gain_g     <= GAIN_ONE;
              gain_b     <= sat_gain(quo_nxt_c, mean_b);
              stat_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          sum_r <= '0;
          sum_g <= '0;
          sum_b <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_PIXCNT_CHECK_EN
  localparam int unsigned PCNT_W = LOG2_PIX + 1;
  localparam logic [PCNT_W-1:0] FRAME_PIX = PCNT_W'(1) << LOG2_PIX;

  logic [PCNT_W-1:0] blue_cnt;

  // Accepted BLUE samples per frame; mismatch latched when means are taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blue_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (state == S_ACC && valid_in && color_in == BLUE) blue_cnt <= blue_cnt + PCNT_W'(1);
      if (state == S_MEAN) frame_err <= (blue_cnt != FRAME_PIX);
      if (state == S_DONE) blue_cnt <= '0;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stat_gain.sv
// Randomized self-checking bench for wb_stat_gain (LOG2_PIX=2: four RGB triples per frame).
`timescale 1ns/1ps
module tb_wb_stat_gain;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned LOG2_PIX = 2;
  localparam int unsigned GAIN_W = 12;
  localparam int NPIX = 4;
  localparam int LAT = 34;
  localparam logic [1:0] C_R = 2'd0, C_G = 2'd1, C_B = 2'd2, C_V = 2'd3;
`ifdef WB_PIXCNT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [PIX_W-1:0] pixel_in = '0;
  logic valid_in = 1'b0, last_pic_in = 1'b0;
  logic [1:0] color_in = C_V;
  logic ready_out, stat_valid, frame_err;
  logic [PIX_W-1:0] mean_r, mean_g, mean_b;
  logic [GAIN_W-1:0] gain_r, gain_g, gain_b;

  wb_stat_gain #(.PIX_W(PIX_W), .LOG2_PIX(LOG2_PIX), .GAIN_FRAC(8), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in),
    .last_pic_in(last_pic_in), .ready_out(ready_out), .mean_r(mean_r), .mean_g(mean_g),
    .mean_b(mean_b), .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
    .stat_valid(stat_valid), .frame_err(frame_err));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] pix; logic [1:0] col; bit last; } samp_t;
  samp_t frame_q[$];
  int fr[NPIX], fg[NPIX], fb[NPIX];
  int n_chk = 0, n_fail = 0;

  int exp_mr, exp_mg, exp_mb, exp_gr, exp_gg, exp_gb;
  logic exp_ferr;
  int got_lat, got_plen;
  logic [PIX_W-1:0] got_mr, got_mg, got_mb, early_mr, early_mg, early_mb;
  logic [GAIN_W-1:0] got_gr, got_gg, got_gb;
  logic got_ferr, got_rdy_busy, got_rdy_after;

  function automatic int ref_gain(input int mg, input int mc);
    int q;
    if (mc == 0) return 4095;
    q = (mg * 256) / mc;
    return (q > 4095) ? 4095 : q;
  endfunction

  // Frame from fr/fg/fb; only the last nb triples carry BLUE so the frame ends on a BLUE sample.
  task automatic build_frame(input int nb, input bit with_void);
    samp_t s;
    frame_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      s.last = 1'b0;
      s.pix = 8'(fr[i]); s.col = C_R; frame_q.push_back(s);
      if (with_void) begin s.pix = 8'($urandom); s.col = C_V; frame_q.push_back(s); end
      s.pix = 8'(fg[i]); s.col = C_G; frame_q.push_back(s);
      if (i >= NPIX - nb) begin s.pix = 8'(fb[i]); s.col = C_B; frame_q.push_back(s); end
    end
    frame_q[frame_q.size()-1].last = 1'b1;
  endtask

  // Reference: gray-world arithmetic straight from the accepted samples
  task automatic compute_expected();
    int sr = 0, sg = 0, sb = 0, nb = 0;
    foreach (frame_q[i]) begin
      case (frame_q[i].col)
        C_R: sr += frame_q[i].pix;
        C_G: sg += frame_q[i].pix;
        C_B: begin sb += frame_q[i].pix; nb++; end
        default: ;
      endcase
    end
    exp_mr = sr / NPIX; exp_mg = sg / NPIX; exp_mb = sb / NPIX;
    exp_gr = ref_gain(exp_mg, exp_mr);
    exp_gb = ref_gain(exp_mg, exp_mb);
    exp_gg = 256;
    exp_ferr = CHK ? (nb != NPIX) : 1'b0;
  endtask

  task automatic send_only();
    foreach (frame_q[i]) begin
      valid_in = 1'b1; pixel_in = frame_q[i].pix;
      color_in = frame_q[i].col; last_pic_in = frame_q[i].last;
      @(posedge clk); #1;
    end
    valid_in = 1'b0; last_pic_in = 1'b0;
  endtask

  // Sends the frame, then observes edges 2.. counted from the edge that sampled last_pic_in.
  task automatic run_frame(input bit drop_busy);
    got_lat = 0; got_plen = 0; got_rdy_after = 1'b0;
    compute_expected();
    send_only();
    got_rdy_busy = ready_out;
    for (int n = 2; n <= 60; n++) begin
      if (drop_busy && n <= LAT + 1) begin
        valid_in = 1'b1; pixel_in = 8'($urandom);
        color_in = 2'($urandom); last_pic_in = 1'($urandom);
      end else begin
        valid_in = 1'b0; last_pic_in = 1'b0;
      end
      @(posedge clk); #1;
      if (n == 2) begin early_mr = mean_r; early_mg = mean_g; early_mb = mean_b; end
      if (stat_valid) begin
        if (got_lat == 0) begin
          got_lat = n; got_gr = gain_r; got_gg = gain_g; got_gb = gain_b;
          got_mr = mean_r; got_mg = mean_g; got_mb = mean_b; got_ferr = frame_err;
        end
        got_plen++;
      end
      if (got_lat != 0 && n == got_lat + 1) begin
        got_rdy_after = ready_out;
        break;
      end
    end
    valid_in = 1'b0; last_pic_in = 1'b0;
  endtask

  task automatic test_reset();
    n_chk += 7;
    if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0d exp=1", ready_out); end
    if (stat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_stat_valid got=%0d exp=0", stat_valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%0d exp=0", frame_err); end
    if ({mean_r, mean_g, mean_b} !== 24'd0) begin n_fail++; $display("FAIL reset_means got=%0d/%0d/%0d exp=0/0/0", mean_r, mean_g, mean_b); end
    if (gain_r !== 12'd256) begin n_fail++; $display("FAIL reset_gain_r got=%0d exp=256", gain_r); end
    if (gain_g !== 12'd256) begin n_fail++; $display("FAIL reset_gain_g got=%0d exp=256", gain_g); end
    if (gain_b !== 12'd256) begin n_fail++; $display("FAIL reset_gain_b got=%0d exp=256", gain_b); end
  endtask

  task automatic test_uniform();
    for (int i = 0; i < NPIX; i++) begin fr[i] = 64; fg[i] = 128; fb[i] = 32; end
    build_frame(NPIX, 1'b0);
    run_frame(1'b0);
    n_chk += 9;
    if (got_lat !== LAT) begin n_fail++; $display("FAIL uni_latency got=%0d exp=%0d", got_lat, LAT); end
    if (got_plen !== 1) begin n_fail++; $display("FAIL uni_pulse_len got=%0d exp=1", got_plen); end
    if (early_mr !== 8'(exp_mr) || early_mg !== 8'(exp_mg) || early_mb !== 8'(exp_mb)) begin
      n_fail++; $display("FAIL uni_mean_early got=%0d/%0d/%0d exp=%0d/%0d/%0d", early_mr, early_mg, early_mb, exp_mr, exp_mg, exp_mb); end
    if (got_gr !== 12'(exp_gr)) begin n_fail++; $display("FAIL uni_gain_r got=%0d exp=%0d", got_gr, exp_gr); end
    if (got_gg !== 12'(exp_gg)) begin n_fail++; $display("FAIL uni_gain_g got=%0d exp=%0d", got_gg, exp_gg); end
    if (got_gb !== 12'(exp_gb)) begin n_fail++; $display("FAIL uni_gain_b got=%0d exp=%0d", got_gb, exp_gb); end
    if (got_rdy_busy !== 1'b0) begin n_fail++; $display("FAIL uni_ready_busy got=%0d exp=0", got_rdy_busy); end
    if (got_rdy_after !== 1'b1) begin n_fail++; $display("FAIL uni_ready_after got=%0d exp=1", got_rdy_after); end
    if (got_ferr !== exp_ferr) begin n_fail++; $display("FAIL uni_frame_err got=%0d exp=%0d", got_ferr, exp_ferr); end
  endtask

  task automatic test_zero_sat();
    for (int i = 0; i < NPIX; i++) begin fr[i] = 0; fg[i] = 255; fb[i] = 8; end
    build_frame(NPIX, 1'b0);
    run_frame(1'b0);
    n_chk += 4;
    if (got_gr !== 12'(exp_gr)) begin n_fail++; $display("FAIL zero_gain_r got=%0d exp=%0d", got_gr, exp_gr); end
    if (got_gb !== 12'(exp_gb)) begin n_fail++; $display("FAIL sat_gain_b got=%0d exp=%0d", got_gb, exp_gb); end
    if (got_gg !== 12'(exp_gg)) begin n_fail++; $display("FAIL zs_gain_g got=%0d exp=%0d", got_gg, exp_gg); end
    if (got_mr !== 8'(exp_mr)) begin n_fail++; $display("FAIL zs_mean_r got=%0d exp=%0d", got_mr, exp_mr); end
  endtask

  task automatic test_trunc_void();
    fr[0] = 1; fr[1] = 2; fr[2] = 2; fr[3] = 2;
    for (int i = 0; i < NPIX; i++) begin fg[i] = 4; fb[i] = 4; end
    build_frame(NPIX, 1'b1);
    run_frame(1'b0);
    n_chk += 4;
    if (got_mr !== 8'(exp_mr)) begin n_fail++; $display("FAIL trunc_mean_r got=%0d exp=%0d", got_mr, exp_mr); end
    if (got_gr !== 12'(exp_gr)) begin n_fail++; $display("FAIL trunc_gain_r got=%0d exp=%0d", got_gr, exp_gr); end
    if (got_mg !== 8'(exp_mg) || got_mb !== 8'(exp_mb)) begin
      n_fail++; $display("FAIL void_means got=%0d/%0d exp=%0d/%0d", got_mg, got_mb, exp_mg, exp_mb); end
    if (got_gb !== 12'(exp_gb)) begin n_fail++; $display("FAIL void_gain_b got=%0d exp=%0d", got_gb, exp_gb); end
  endtask

  task automatic test_dropped();
    for (int i = 0; i < NPIX; i++) begin fr[i] = $urandom_range(1, 255); fg[i] = $urandom_range(1, 255); fb[i] = $urandom_range(1, 255); end
    build_frame(NPIX, 1'b0);
    run_frame(1'b1);
    for (int i = 0; i < NPIX; i++) begin fr[i] = 100; fg[i] = 100; fb[i] = 100; end
    build_frame(NPIX, 1'b0);
    run_frame(1'b0);
    n_chk += 4;
    if (got_lat !== LAT) begin n_fail++; $display("FAIL drop_latency got=%0d exp=%0d", got_lat, LAT); end
    if (got_mr !== 8'(exp_mr) || got_mg !== 8'(exp_mg) || got_mb !== 8'(exp_mb)) begin
      n_fail++; $display("FAIL drop_means got=%0d/%0d/%0d exp=%0d/%0d/%0d", got_mr, got_mg, got_mb, exp_mr, exp_mg, exp_mb); end
    if ({got_gr, got_gg, got_gb} !== {12'(exp_gr), 12'(exp_gg), 12'(exp_gb)}) begin
      n_fail++; $display("FAIL drop_gains got=%0d/%0d/%0d exp=%0d/%0d/%0d", got_gr, got_gg, got_gb, exp_gr, exp_gg, exp_gb); end
    if (got_ferr !== exp_ferr) begin n_fail++; $display("FAIL drop_frame_err got=%0d exp=%0d", got_ferr, exp_ferr); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    for (int i = 0; i < NPIX; i++) begin fr[i] = 50; fg[i] = 200; fb[i] = 70; end
    build_frame(NPIX, 1'b0);
    send_only();
    repeat (24) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_chk += 3;
    if ({gain_r, gain_g, gain_b} !== {12'd256, 12'd256, 12'd256}) begin
      n_fail++; $display("FAIL rmid_gains got=%0d/%0d/%0d exp=256/256/256", gain_r, gain_g, gain_b); end
    if ({mean_r, mean_g, mean_b} !== 24'd0) begin n_fail++; $display("FAIL rmid_means got=%0d/%0d/%0d exp=0", mean_r, mean_g, mean_b); end
    if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%0d exp=1", ready_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (stat_valid) pulses++; end
    n_chk++;
    if (pulses !== 0) begin n_fail++; $display("FAIL rmid_no_stat got=%0d exp=0", pulses); end
    run_frame(1'b0);
    n_chk += 2;
    if (got_lat !== LAT) begin n_fail++; $display("FAIL rmid_next_latency got=%0d exp=%0d", got_lat, LAT); end
    if ({got_gr, got_gb, got_mg} !== {12'(exp_gr), 12'(exp_gb), 8'(exp_mg)}) begin
      n_fail++; $display("FAIL rmid_next_result got=%0d/%0d/%0d exp=%0d/%0d/%0d", got_gr, got_gb, got_mg, exp_gr, exp_gb, exp_mg); end
  endtask

  task automatic test_pixcnt();
    for (int i = 0; i < NPIX; i++) begin fr[i] = 40; fg[i] = 80; fb[i] = 60; end
    build_frame(NPIX - 1, 1'b0);
    run_frame(1'b0);
    n_chk += 2;
    if (got_ferr !== exp_ferr) begin n_fail++; $display("FAIL pix3_frame_err got=%0d exp=%0d", got_ferr, exp_ferr); end
    if (got_gb !== 12'(exp_gb)) begin n_fail++; $display("FAIL pix3_gain_b got=%0d exp=%0d", got_gb, exp_gb); end
    n_chk++;
    if (frame_err !== exp_ferr) begin n_fail++; $display("FAIL pix3_err_hold got=%0d exp=%0d", frame_err, exp_ferr); end
    build_frame(NPIX, 1'b0);
    run_frame(1'b0);
    n_chk++;
    if (got_ferr !== exp_ferr) begin n_fail++; $display("FAIL pix4_frame_err got=%0d exp=%0d", got_ferr, exp_ferr); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        fr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
        fg[i] = $urandom_range(0, 255);
        fb[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      end
      build_frame(NPIX, 1'($urandom));
      run_frame(1'($urandom));
      n_chk += 3;
      if (got_lat !== LAT || got_plen !== 1) begin
        n_fail++; $display("FAIL rnd%0d_timing lat=%0d len=%0d exp=%0d/1", f, got_lat, got_plen, LAT); end
      if (got_mr !== 8'(exp_mr) || got_mg !== 8'(exp_mg) || got_mb !== 8'(exp_mb)) begin
        n_fail++; $display("FAIL rnd%0d_means got=%0d/%0d/%0d exp=%0d/%0d/%0d", f, got_mr, got_mg, got_mb, exp_mr, exp_mg, exp_mb); end
      if ({got_gr, got_gg, got_gb} !== {12'(exp_gr), 12'(exp_gg), 12'(exp_gb)}) begin
        n_fail++; $display("FAIL rnd%0d_gains got=%0d/%0d/%0d exp=%0d/%0d/%0d", f, got_gr, got_gg, got_gb, exp_gr, exp_gg, exp_gb); end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_uniform();
    test_zero_sat();
    test_trunc_void();
    test_dropped();
    test_reset_mid();
    test_pixcnt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
